fifo_stream_reader: RTL and testbench

Drain-side companion to the line-buffer FIFO. It issues pops on the FIFO read port and absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer. It presents the words as a valid/ready stream to the downstream CNN/BiLSTM stage at full throughput (one word per cycle) without losing data under backpressure. It also provides run/stop control and optional frame-boundary marking.

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 126 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bus: FIFO read port on one side, valid/ready output stream on the other.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO drain into a valid/ready stream through a 2-entry skid buffer with run/stop control.
// Optional frame marking (m_last, frame-complete stop) under FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic                 busy
);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  valid_q, busy_q;
  logic                  issue_c, stop_issue_c, pop_c, cap_c, rd_en_c;
  logic [2:0]            fill_c;

  // Run/stop control
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        issue_c = 1'b1;
        if (!enable) state_d = STOP;
      end
      STOP: begin
        issue_c = stop_issue_c;
        if (enable)
          state_d = RUN;
        else if (!stop_issue_c && !inflight_q && (occ_q == 2'd0))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: head is the oldest word; a capture never lands in a full buffer unless it pops
  always_comb begin
    pop_c    = valid_q & bus.m_ready;
    cap_c    = bus.fifo_rd_valid & inflight_q & (pop_c | (occ_q != 2'd2));
    fill_c   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_c};
    rd_en_c  = issue_c & ~bus.fifo_empty & (fill_c < 3'd2);
    head_d   = head_q;
    tail_d   = tail_q;
    occ_d    = occ_q;
    if (pop_c) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end
    if (cap_c) begin
      if (occ_d == 2'd0) head_d = bus.fifo_rd_data;
      else               tail_d = bus.fifo_rd_data;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= rd_en_c;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= (occ_d != 2'd0);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_data     = head_q;
  assign bus.m_valid    = valid_q;
  assign busy           = busy_q;

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d, iss_cnt_q, iss_cnt_d;
  logic             last_q;

  // Delivered and issued word positions within the current frame
  always_comb begin
    out_cnt_d = out_cnt_q;
    iss_cnt_d = iss_cnt_q;
    if (pop_c)   out_cnt_d = (out_cnt_q == CNT_MAX) ? '0 : out_cnt_q + CNT_W'(1);
    if (rd_en_c) iss_cnt_d = (iss_cnt_q == CNT_MAX) ? '0 : iss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      iss_cnt_q <= '0;
      last_q    <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      last_q    <= (occ_d != 2'd0) && (out_cnt_d == CNT_MAX);
    end
  end

  // A stop keeps popping until the frame in progress has been fully issued
  assign stop_issue_c = (iss_cnt_q != '0);
  assign bus.m_last   = last_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^CNT_W'(FRAME_LEN);
  assign stop_issue_c = 1'b0;
  assign bus.m_last   = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model with one-cycle read latency, stream monitor.
module tb_fifo_stream_reader;
  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic busy;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // FIFO model: pop on fifo_rd_en, data returned one cycle later
  logic [DW-1:0] mem [0:255];
  int n_pushed = 0;
  int n_popped = 0;
  assign bus.fifo_empty = (n_pushed == n_popped);

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.fifo_rd_valid <= 1'b0;
    end else if (bus.fifo_rd_en && (n_pushed != n_popped)) begin
      bus.fifo_rd_data  <= mem[n_popped[7:0]];
      bus.fifo_rd_valid <= 1'b1;
      n_popped          <= n_popped + 1;
    end else begin
      bus.fifo_rd_valid <= 1'b0;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[n_pushed[7:0]] = w;
    n_pushed++;
  endtask

  // Stream monitor: records handshakes, checks hold-stability and the pop rule every cycle
  logic [DW-1:0] got [$];
  logic          got_last [$];
  int            mon_occ = 0;
  int            mon_infl = 0;
  int            mon_pop;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_occ   = 0;
      mon_infl  = 0;
      prev_hold = 1'b0;
    end else begin
      mon_pop = (bus.m_valid && bus.m_ready) ? 1 : 0;
      check("valid_vs_occ", 32'(bus.m_valid), 32'(mon_occ != 0));
      if (bus.fifo_rd_en) check("pop_rule", 32'((mon_occ + mon_infl - mon_pop) < 2), 32'd1);
      if (prev_hold) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (mon_pop == 1) begin
        got.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      mon_occ   = mon_occ + ((bus.fifo_rd_valid && (mon_infl == 1)) ? 1 : 0) - mon_pop;
      mon_infl  = bus.fifo_rd_en ? 1 : 0;
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  function automatic logic [31:0] gw(input int k);
    return (got.size() > k) ? 32'(got[k]) : 32'hDEAD_0000;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    int i = 0;
    while (got.size() < n && i < budget) begin
      @(posedge clk);
      #2;
      i++;
    end
  endtask

  task automatic clear_got();
    got.delete();
    got_last.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] pat;
    pat = 64'hC9A5_3E17_B46D_82F3;
    rst_n = 1'b0;
    enable = 1'b0;
    bus.m_ready = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_last", 32'(bus.m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

`ifdef FIFO_STREAM_READER_LAST_EN
    clear_got();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) push(16'h0500 + 16'(i));
    enable = 1'b1;
    wait_got(12, 100);
    check("frame_count", 32'(got.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      check($sformatf("m_last_%0d", k), 32'(got_last.size() > k ? got_last[k] : 1'bx), 32'((k % 4) == 3));
    clear_got();
    for (int i = 1; i <= 8; i++) push(16'h0600 + 16'(i));
    tick(1);
    enable = 1'b0;
    tick(12);
    check("frame_stop_count", 32'(got.size()), 32'd4);
    check("frame_stop_w3", gw(2), 32'h0603);
    check("frame_stop_w4", gw(3), 32'h0604);
    check("frame_stop_last", 32'(got_last.size() > 3 ? got_last[3] : 1'bx), 32'd1);
    check("frame_stop_busy", 32'(busy), 32'd0);
    check("frame_stop_left", 32'(n_pushed - n_popped), 32'd4);
    enable = 1'b1;
    wait_got(8, 50);
    enable = 1'b0;
    tick(6);
    check("frame_drain_busy", 32'(busy), 32'd0);
`endif

    // Full-rate streaming from an idle start
    clear_got();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(16'(i));
    enable = 1'b1;
    @(negedge clk);
    check("start_t0_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    check("start_t1_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    check("start_t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_t2_valid", 32'(bus.m_valid), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("stream_valid_%0d", k), 32'(bus.m_valid), 32'd1);
      check($sformatf("stream_data_%0d", k), 32'(bus.m_data), 32'(k));
    end
    @(negedge clk);
    check("stream_end_valid", 32'(bus.m_valid), 32'd0);
    tick(1);

    // Backpressure with an irregular ready pattern
    clear_got();
    for (int i = 1; i <= 16; i++) push(16'h0200 + 16'(i));
    for (int c = 0; c < 300 && got.size() < 16; c++) begin
      bus.m_ready = pat[c % 64];
      tick(1);
    end
    bus.m_ready = 1'b1;
    tick(4);
    check("bp_count", 32'(got.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      check($sformatf("bp_word_%0d", k), gw(k), 32'h0200 + 32'(k + 1));

    // Drain to empty, then a single late word
    clear_got();
    for (int i = 1; i <= 3; i++) push(16'h0300 + 16'(i));
    tick(8);
    check("empty_count", 32'(got.size()), 32'd3);
    @(negedge clk);
    check("empty_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("empty_valid", 32'(bus.m_valid), 32'd0);
    tick(1);
    push(16'hBEEF);
    @(negedge clk);
    check("refill_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("refill_valid", 32'(bus.m_valid), 32'd1);
    check("refill_data", 32'(bus.m_data), 32'h0000_BEEF);
    tick(1);

`ifndef FIFO_STREAM_READER_LAST_EN
    // Stop mid-stream: only already-issued words come out
    clear_got();
    for (int i = 1; i <= 16; i++) push(16'h0400 + 16'(i));
    tick(4);
    enable = 1'b0;
    @(negedge clk);
    check("stop_edge_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stop_no_pop_%0d", k), 32'(bus.fifo_rd_en), 32'd0);
    end
    tick(1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_count", 32'(got.size()), 32'd5);
    check("stop_w1", gw(0), 32'h0401);
    check("stop_w5", gw(4), 32'h0405);
    check("stop_left", 32'(n_pushed - n_popped), 32'd11);
    enable = 1'b1;
    wait_got(16, 100);
    check("resume_w6", gw(5), 32'h0406);
    check("resume_w16", gw(15), 32'h0410);
    tick(2);
`endif

    // Asynchronous reset with a full buffer
    clear_got();
    bus.m_ready = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) push(16'h0A00 + 16'(i));
    tick(6);
    @(negedge clk);
    check("full_valid", 32'(bus.m_valid), 32'd1);
    check("full_data", 32'(bus.m_data), 32'h0A01);
    check("full_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("full_left", 32'(n_pushed - n_popped), 32'd4);
    tick(1);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("arst_valid", 32'(bus.m_valid), 32'd0);
    check("arst_last", 32'(bus.m_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(bus.m_data), 32'd0);
    tick(2);
    clear_got();
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    enable = 1'b1;
    wait_got(4, 50);
    check("post_rst_count", 32'(got.size()), 32'd4);
    check("post_rst_head", gw(0), 32'h0A03);
    check("post_rst_tail", gw(3), 32'h0A06);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
